// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: checks each request, drives the data-memory strobes,
// and returns one response per accepted request, held stable while the pipeline stalls.
module mem_access_unit #(
    parameter int unsigned DMEM_BYTES = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        stall,
    input  logic        flush,
    output logic        req_ready,
    output logic [31:0] addrD,
    output logic        renD,
    output logic        wenD,
    output logic [31:0] wdataD,
    output logic [3:0]  MaskD,
    input  logic [31:0] rdataD,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_fault
);
    // state     | meaning
    // IDLE      | no response outstanding
    // LOAD_PEND | load issued last cycle, result taken live from rdataD
    // RESP      | registered store or fault response
    // HOLD      | load result captured while stalled
    typedef enum logic [1:0] {IDLE, LOAD_PEND, RESP, HOLD} state_t;

    localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_BYTES);

    state_t      state, state_nx;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic [31:0] hold_data;
    logic [31:0] resp_reg;
    logic        fault_reg;

    logic        accept;
    logic        req_fault;
    logic        bad_funct3;
    logic        misaligned;
    logic [31:0] lane;
    logic [31:0] load_data;

    assign req_ready = !stall && !flush && rst_n;
    assign accept    = req_valid && req_ready;
    assign addrD     = addr;

    always_comb begin
        bad_funct3 = req_load ? (funct3 == 3'd3 || funct3[2:1] == 2'b11) : (funct3 > 3'd2);
        misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == 3'd2 && addr[1:0] != 2'b00);
        req_fault  = (req_load == req_store) || bad_funct3 || misaligned || (addr >= DMEM_LIMIT);
    end

    always_comb begin
        lane = rdataD >> {ld_off, 3'b000};
        case (ld_funct3)
            3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_data = {24'd0, lane[7:0]};
            3'd5:    load_data = {16'd0, lane[15:0]};
            default: load_data = rdataD;
        endcase
    end

    // Strobes derive from accept, which already includes rst_n, so reset silences the port.
    always_comb begin
        renD   = 1'b0;
        wenD   = 1'b0;
        MaskD  = 4'b0000;
        wdataD = 32'd0;
        if (accept && !req_fault) begin
            if (req_load) begin
                renD = 1'b1;
            end else begin
                wenD = 1'b1;
                case (funct3[1:0])
                    2'b00: begin
                        MaskD  = 4'b0001 << addr[1:0];
                        wdataD = {4{store_data[7:0]}};
                    end
                    2'b01: begin
                        MaskD  = addr[1] ? 4'b1100 : 4'b0011;
                        wdataD = {2{store_data[15:0]}};
                    end
                    default: begin
                        MaskD  = 4'b1111;
                        wdataD = store_data;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else if (accept) begin
            state_nx = (req_load && !req_fault) ? LOAD_PEND : RESP;
        end else if (stall) begin
            if (state == LOAD_PEND) state_nx = HOLD;
        end else begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        resp_valid = (state != IDLE);
        resp_fault = (state == RESP) && fault_reg;
        case (state)
            LOAD_PEND: resp_data = load_data;
            HOLD:      resp_data = hold_data;
            RESP:      resp_data = resp_reg;
            default:   resp_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ld_funct3 <= 3'd0;
            ld_off    <= 2'd0;
            hold_data <= 32'd0;
            resp_reg  <= 32'd0;
            fault_reg <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ld_funct3 <= funct3;
                ld_off    <= addr[1:0];
                resp_reg  <= req_fault ? addr : 32'd0;
                fault_reg <= req_fault;
            end
            if (state == LOAD_PEND && stall && !flush)
                hold_data <= load_data;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed memory plus a request-level reference model,
// directed scenarios followed by randomized traffic.
module tb_mem_access_unit;
    localparam int DMEM = 131072;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        req_ready, renD, wenD, resp_valid, resp_fault;
    logic [31:0] addrD, wdataD, rdataD, resp_data;
    logic [3:0]  MaskD;

    bit [7:0] bus_mem [DMEM];
    bit [7:0] ref_mem [DMEM];

    int checks = 0;
    int errors = 0;

    logic        pend_v = 1'b0, pend_f = 1'b0;
    logic [31:0] pend_d = 32'd0;

    mem_access_unit #(.DMEM_BYTES(DMEM)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_load(req_load),
        .req_store(req_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall), .flush(flush), .req_ready(req_ready), .addrD(addrD),
        .renD(renD), .wenD(wenD), .wdataD(wdataD), .MaskD(MaskD), .rdataD(rdataD),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    // Synchronous memory driven only by the DUT's strobes.
    always @(posedge clk) begin
        int base;
        base = int'({addrD[31:2], 2'b00});
        if (wenD && addrD < DMEM)
            for (int i = 0; i < 4; i++)
                if (MaskD[i]) bus_mem[base + i] = wdataD[8*i +: 8];
        if (renD && addrD < DMEM)
            rdataD <= {bus_mem[base + 3], bus_mem[base + 2], bus_mem[base + 1], bus_mem[base]};
        else
            rdataD <= $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_fault(input logic ld, input logic st, input logic [2:0] f,
                                         input logic [31:0] a);
        if (ld == st) return 1'b1;
        if (a >= DMEM) return 1'b1;
        if (ld && (f == 3 || f == 6 || f == 7)) return 1'b1;
        if (st && f > 2) return 1'b1;
        if (f[1:0] == 2'd1 && a[0]) return 1'b1;
        if (f[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a);
        int ai;
        logic [7:0]  b;
        logic [15:0] h;
        ai = int'(a);
        b  = ref_mem[ai];
        h  = {ref_mem[ai + 1], ref_mem[ai]};
        case (f)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return {ref_mem[ai + 3], ref_mem[ai + 2], ref_mem[ai + 1], ref_mem[ai]};
        endcase
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance the model.
    task automatic cyc(input logic v, input logic ld, input logic st, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] sd, input logic stl,
                       input logic fl);
        logic acc, flt, wr;
        int   n;
        logic [3:0]  em;
        logic [31:0] ew;
        req_valid = v; req_load = ld; req_store = st; funct3 = f;
        addr = a; store_data = sd; stall = stl; flush = fl;
        @(negedge clk);
        acc = v && !stl && !fl && rst_n;
        flt = model_fault(ld, st, f, a);
        wr  = acc && !flt && st;
        chk("req_ready", req_ready, !stl && !fl && rst_n);
        chk("resp_valid", resp_valid, pend_v);
        if (pend_v) begin
            chk("resp_fault", resp_fault, pend_f);
            chk("resp_data", resp_data, pend_d);
        end
        chk("renD", renD, acc && !flt && ld);
        chk("wenD", wenD, wr);
        n  = 1 << f[1:0];
        em = wr ? 4'(((1 << n) - 1) << a[1:0]) : 4'd0;
        ew = !wr ? 32'd0 : (n == 1) ? {4{sd[7:0]}} : (n == 2) ? {2{sd[15:0]}} : sd;
        chk("MaskD", MaskD, em);
        chk("wdataD", wdataD, ew);
        if (v) chk("addrD", addrD, a);
        if (!rst_n || fl) begin
            pend_v = 1'b0;
        end else if (acc) begin
            pend_v = 1'b1;
            pend_f = flt;
            pend_d = flt ? a : (ld ? load_val(f, a) : 32'd0);
            if (wr)
                for (int i = 0; i < n; i++)
                    ref_mem[int'(a) + i] = sd[8*i +: 8];
        end else if (!stl) begin
            pend_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic stl, input logic fl);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, stl, fl);
    endtask

    initial begin
        for (int i = 0; i < DMEM; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        {bus_mem[259], bus_mem[258], bus_mem[257], bus_mem[256]} = 32'h8081F2F3;
        {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]} = 32'h8081F2F3;

        #1;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_fault", resp_fault, 1'b0);
        chk("rst_resp_data", resp_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        cyc(1, 1, 0, 3'd0, 32'h101, 0, 0, 0);
        chk("tp_lb", resp_data, 32'hFFFFFFF2);
        cyc(1, 1, 0, 3'd4, 32'h101, 0, 0, 0);
        chk("tp_lbu", resp_data, 32'h000000F2);
        cyc(1, 0, 1, 3'd1, 32'h102, 32'h0000ABCD, 0, 0);
        cyc(1, 1, 0, 3'd2, 32'h100, 0, 0, 0);
        chk("tp_lw", resp_data, 32'hABCDF2F3);
        cyc(1, 1, 0, 3'd2, 32'h102, 0, 0, 0);
        cyc(1, 1, 0, 3'd2, 32'h0002_0000, 0, 0, 0);
        chk("tp_range_addr", resp_data, 32'h0002_0000);
        cyc(1, 1, 0, 3'd1, 32'h100, 0, 0, 0);
        idle(1, 0);
        idle(1, 0);
        idle(1, 0);
        chk("tp_hold", resp_data, 32'hFFFFF2F3);
        cyc(1, 1, 0, 3'd2, 32'h104, 0, 0, 0);
        cyc(1, 1, 0, 3'd2, 32'h104, 0, 0, 0);
        cyc(1, 0, 1, 3'd2, 32'h108, 32'h1234_5678, 0, 1);
        idle(0, 0);
        cyc(1, 1, 0, 3'd2, 32'h0001_FFFC, 0, 0, 0);
        cyc(1, 0, 1, 3'd0, 32'h0001_FFFF, 32'h5A, 0, 0);
        cyc(1, 1, 0, 3'd4, 32'h0001_FFFF, 0, 0, 0);
        cyc(1, 1, 1, 3'd2, 32'h100, 0, 0, 0);
        cyc(1, 0, 0, 3'd2, 32'h100, 0, 0, 0);
        cyc(1, 0, 1, 3'd3, 32'h100, 0, 0, 0);
        idle(0, 0);

        for (int k = 0; k < 500; k++) begin
            logic        v, ld, st, stl, fl;
            logic [2:0]  f;
            logic [31:0] a;
            int          r;
            v   = ($urandom % 4) != 0;
            r   = $urandom % 16;
            ld  = (r < 7) || (r == 15);
            st  = (r >= 7 && r < 14) || (r == 15);
            f   = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom_range(0, 2) + (($urandom % 2) ? 4 : 0));
            a   = ($urandom % 16 == 0) ? 32'h0001_FFF8 + $urandom_range(0, 15)
                                       : 32'h100 + $urandom_range(0, 63);
            stl = ($urandom % 5) == 0;
            fl  = ($urandom % 12) == 0;
            cyc(v, ld, st, f, a, $urandom, stl, fl);
        end
        idle(0, 0);

        cyc(1, 1, 0, 3'd1, 32'h100, 0, 0, 0);
        idle(1, 0);
        idle(1, 0);
        rst_n     = 1'b0;
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
        funct3 = 3'd2; addr = 32'h100; stall = 1'b0; flush = 1'b0;
        #1;
        chk("arst_resp_valid", resp_valid, 1'b0);
        chk("arst_resp_fault", resp_fault, 1'b0);
        chk("arst_resp_data", resp_data, 32'd0);
        chk("arst_renD", renD, 1'b0);
        chk("arst_wenD", wenD, 1'b0);
        chk("arst_MaskD", MaskD, 4'd0);
        pend_v = 1'b0;
        cyc(1, 1, 0, 3'd2, 32'h100, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1, 1, 0, 3'd2, 32'h100, 0, 0, 0);
        idle(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
